// File: rtl/ct_had_mbkpt_match_if.sv
// Signal bundle between the HAD memory-breakpoint matcher and its retire/LSU/DR-update sources
// and the downstream breakpoint counter. The master modport is the matcher side.
interface ct_had_mbkpt_match_if #(
    parameter int VA_WIDTH = 40
);
    logic                x_sm_xx_update_dr_en;
    logic                ir_xx_bab_reg_sel;
    logic                ir_xx_bamr_reg_sel;
    logic                ir_xx_bcfg_reg_sel;
    logic [63:0]         ir_xx_wdata;
    logic                ctrl_bkpt_en;
    logic                rtu_had_retire_vld;
    logic [VA_WIDTH-1:0] rtu_had_retire_pc;
    logic                rtu_had_retire_normal;
    logic                rtu_had_retire_split;
    logic                rtu_had_retire_chgflow;
    logic                lsu_had_data_vld;
    logic [VA_WIDTH-1:0] lsu_had_data_addr;
    logic                lsu_had_data_st;
    logic                rtu_yy_xx_flush;
    logic                rtu_yy_xx_dbgon;
    logic                mbkpt_inst_bkpt_vld;
    logic                mbkpt_data_bkpt_vld;
    logic                mbkpt_inst_bkpt_inst_vld;
    logic                mbkpt_inst_split;
    logic                mbkpt_xx_chgflow;
    logic                mbkpt_data_st;
    logic                mbkpt_xx_inst_ack;
    logic                mbkpt_xx_data_ack;
    logic [VA_WIDTH-1:0] mbkpt_regs_bab;
    logic [VA_WIDTH-1:0] mbkpt_regs_bamr;
    logic [1:0]          mbkpt_regs_bcfg;

    modport master (
        input  x_sm_xx_update_dr_en, ir_xx_bab_reg_sel, ir_xx_bamr_reg_sel, ir_xx_bcfg_reg_sel,
               ir_xx_wdata, ctrl_bkpt_en, rtu_had_retire_vld, rtu_had_retire_pc,
               rtu_had_retire_normal, rtu_had_retire_split, rtu_had_retire_chgflow,
               lsu_had_data_vld, lsu_had_data_addr, lsu_had_data_st, rtu_yy_xx_flush,
               rtu_yy_xx_dbgon,
        output mbkpt_inst_bkpt_vld, mbkpt_data_bkpt_vld, mbkpt_inst_bkpt_inst_vld,
               mbkpt_inst_split, mbkpt_xx_chgflow, mbkpt_data_st, mbkpt_xx_inst_ack,
               mbkpt_xx_data_ack, mbkpt_regs_bab, mbkpt_regs_bamr, mbkpt_regs_bcfg
    );

    modport slave (
        output x_sm_xx_update_dr_en, ir_xx_bab_reg_sel, ir_xx_bamr_reg_sel, ir_xx_bcfg_reg_sel,
               ir_xx_wdata, ctrl_bkpt_en, rtu_had_retire_vld, rtu_had_retire_pc,
               rtu_had_retire_normal, rtu_had_retire_split, rtu_had_retire_chgflow,
               lsu_had_data_vld, lsu_had_data_addr, lsu_had_data_st, rtu_yy_xx_flush,
               rtu_yy_xx_dbgon,
        input  mbkpt_inst_bkpt_vld, mbkpt_data_bkpt_vld, mbkpt_inst_bkpt_inst_vld,
               mbkpt_inst_split, mbkpt_xx_chgflow, mbkpt_data_st, mbkpt_xx_inst_ack,
               mbkpt_xx_data_ack, mbkpt_regs_bab, mbkpt_regs_bamr, mbkpt_regs_bcfg
    );
endinterface

// File: rtl/ct_had_mbkpt_match.sv
// HAD memory-breakpoint matcher: compares retiring PCs and LSU data addresses against the
// debugger-programmed BAB/BAMR/BCFG registers and drives registered occurrence/ack levels.
module ct_had_mbkpt_match #(
    parameter int VA_WIDTH = 40
) (
    input  logic                    cpuclk,
    input  logic                    cpurst_b,
    ct_had_mbkpt_match_if.master    bus
);

    logic [VA_WIDTH-1:0] bab_r;
    logic [VA_WIDTH-1:0] bamr_r;
    logic [1:0]          bcfg_r;
    logic                pend_r;
    logic                pend_st_r;
    logic                inst_vld_r;
    logic                inst_bkpt_r;
    logic                split_r;
    logic                chgflow_r;
    logic                data_bkpt_r;
    logic                data_st_r;
    logic                inst_ack_r;
    logic                data_ack_r;

    logic                inst_hit_s;
    logic                data_hit_s;
    logic                consume_s;
    logic                deliver_s;
    logic                retire_s;
    logic                unused_wdata_s;

    // BAMR bit set means that address bit is ignored; RC inverts the equality result.
    function automatic logic bkpt_hit(
        input logic [VA_WIDTH-1:0] addr,
        input logic [VA_WIDTH-1:0] bab,
        input logic [VA_WIDTH-1:0] bamr,
        input logic [1:0]          cfg,
        input logic                gen_en,
        input logic                dbgon
    );
        logic eq;
        eq = (((addr ^ bab) & ~bamr) == {VA_WIDTH{1'b0}});
        return cfg[0] & gen_en & ~dbgon & (eq ^ cfg[1]);
    endfunction

    assign unused_wdata_s = ^bus.ir_xx_wdata[63:VA_WIDTH];

    // Compare results and retire qualifiers for the current cycle.
    always_comb begin
        inst_hit_s = 1'b0;
        data_hit_s = 1'b0;
        consume_s  = 1'b0;
        deliver_s  = 1'b0;
        retire_s   = 1'b0;
        inst_hit_s = bkpt_hit(bus.rtu_had_retire_pc, bab_r, bamr_r, bcfg_r,
                              bus.ctrl_bkpt_en, bus.rtu_yy_xx_dbgon);
        data_hit_s = bkpt_hit(bus.lsu_had_data_addr, bab_r, bamr_r, bcfg_r,
                              bus.ctrl_bkpt_en, bus.rtu_yy_xx_dbgon);
        retire_s   = bus.rtu_had_retire_vld & ~bus.rtu_yy_xx_flush;
        consume_s  = bus.rtu_had_retire_vld & bus.rtu_had_retire_normal & ~bus.rtu_had_retire_split;
        deliver_s  = consume_s & pend_r & ~bus.rtu_yy_xx_flush;
    end

    // Debugger-visible breakpoint registers, loaded on DR update.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            bab_r  <= {VA_WIDTH{1'b0}};
            bamr_r <= {VA_WIDTH{1'b0}};
            bcfg_r <= 2'b00;
        end else begin
            if (bus.x_sm_xx_update_dr_en && bus.ir_xx_bab_reg_sel)
                bab_r <= bus.ir_xx_wdata[VA_WIDTH-1:0];
            if (bus.x_sm_xx_update_dr_en && bus.ir_xx_bamr_reg_sel)
                bamr_r <= bus.ir_xx_wdata[VA_WIDTH-1:0];
            if (bus.x_sm_xx_update_dr_en && bus.ir_xx_bcfg_reg_sel)
                bcfg_r <= bus.ir_xx_wdata[1:0];
        end
    end

    // Data-hit pending flag; a new hit wins over a same-cycle consume so it waits for the next retire.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            pend_r    <= 1'b0;
            pend_st_r <= 1'b0;
        end else if (bus.rtu_yy_xx_flush || bus.rtu_yy_xx_dbgon) begin
            pend_r    <= 1'b0;
            pend_st_r <= 1'b0;
        end else if (bus.lsu_had_data_vld && data_hit_s) begin
            pend_r    <= 1'b1;
            pend_st_r <= bus.lsu_had_data_st;
        end else if (consume_s) begin
            pend_r    <= 1'b0;
        end
    end

    // Registered occurrence levels and the acks that trail them by one cycle.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            inst_vld_r  <= 1'b0;
            inst_bkpt_r <= 1'b0;
            split_r     <= 1'b0;
            chgflow_r   <= 1'b0;
            data_bkpt_r <= 1'b0;
            data_st_r   <= 1'b0;
            inst_ack_r  <= 1'b0;
            data_ack_r  <= 1'b0;
        end else begin
            inst_vld_r  <= retire_s;
            inst_bkpt_r <= retire_s & bus.rtu_had_retire_normal & inst_hit_s;
            split_r     <= retire_s & bus.rtu_had_retire_split;
            chgflow_r   <= retire_s & bus.rtu_had_retire_chgflow;
            data_bkpt_r <= deliver_s;
            data_st_r   <= deliver_s & pend_st_r;
            inst_ack_r  <= inst_bkpt_r & ~bus.rtu_yy_xx_flush;
            data_ack_r  <= data_bkpt_r & ~bus.rtu_yy_xx_flush;
        end
    end

    assign bus.mbkpt_inst_bkpt_vld      = inst_bkpt_r;
    assign bus.mbkpt_data_bkpt_vld      = data_bkpt_r;
    assign bus.mbkpt_inst_bkpt_inst_vld = inst_vld_r;
    assign bus.mbkpt_inst_split         = split_r;
    assign bus.mbkpt_xx_chgflow         = chgflow_r;
    assign bus.mbkpt_data_st            = data_st_r;
    assign bus.mbkpt_xx_inst_ack        = inst_ack_r;
    assign bus.mbkpt_xx_data_ack        = data_ack_r;
    assign bus.mbkpt_regs_bab           = bab_r;
    assign bus.mbkpt_regs_bamr          = bamr_r;
    assign bus.mbkpt_regs_bcfg          = bcfg_r;

endmodule

// File: tb/tb_ct_had_mbkpt_match.sv
// Directed scoreboard bench for ct_had_mbkpt_match; expected output vectors are
// {inst_vld, inst_bkpt, split, chgflow, data_bkpt, data_st, inst_ack, data_ack}.
module tb_ct_had_mbkpt_match;
    localparam int VA = 40;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    logic cpuclk;
    logic cpurst_b;
    int   n_cmp;
    int   n_fail;
    sb_t  sbq[$];

    ct_had_mbkpt_match_if #(.VA_WIDTH(VA)) bus ();

    ct_had_mbkpt_match #(.VA_WIDTH(VA)) dut (
        .cpuclk   (cpuclk),
        .cpurst_b (cpurst_b),
        .bus      (bus)
    );

    initial begin
        cpuclk = 1'b0;
        forever #5 cpuclk = ~cpuclk;
    end

    function automatic logic [7:0] outs();
        return {bus.mbkpt_inst_bkpt_inst_vld, bus.mbkpt_inst_bkpt_vld, bus.mbkpt_inst_split,
                bus.mbkpt_xx_chgflow, bus.mbkpt_data_bkpt_vld, bus.mbkpt_data_st,
                bus.mbkpt_xx_inst_ack, bus.mbkpt_xx_data_ack};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.x_sm_xx_update_dr_en   = 1'b0;
        bus.ir_xx_bab_reg_sel      = 1'b0;
        bus.ir_xx_bamr_reg_sel     = 1'b0;
        bus.ir_xx_bcfg_reg_sel     = 1'b0;
        bus.ir_xx_wdata            = 64'h0;
        bus.rtu_had_retire_vld     = 1'b0;
        bus.rtu_had_retire_pc      = 40'h0;
        bus.rtu_had_retire_normal  = 1'b0;
        bus.rtu_had_retire_split   = 1'b0;
        bus.rtu_had_retire_chgflow = 1'b0;
        bus.lsu_had_data_vld       = 1'b0;
        bus.lsu_had_data_addr      = 40'h0;
        bus.lsu_had_data_st        = 1'b0;
        bus.rtu_yy_xx_flush        = 1'b0;
        bus.rtu_yy_xx_dbgon        = 1'b0;
    endtask

    // push the expectation for this cycle, clock it, then pop and compare
    task automatic step(input string tag, input logic [7:0] exp);
        sb_t e;
        sbq.push_back('{tag, exp});
        @(posedge cpuclk);
        #1;
        e = sbq.pop_front();
        check(e.tag, {56'h0, outs()}, {56'h0, e.exp});
        idle_inputs();
    endtask

    task automatic retire(input logic [39:0] pc, input logic split, input logic chg);
        bus.rtu_had_retire_vld     = 1'b1;
        bus.rtu_had_retire_pc      = pc;
        bus.rtu_had_retire_normal  = 1'b1;
        bus.rtu_had_retire_split   = split;
        bus.rtu_had_retire_chgflow = chg;
    endtask

    task automatic lsu(input logic [39:0] addr, input logic st);
        bus.lsu_had_data_vld  = 1'b1;
        bus.lsu_had_data_addr = addr;
        bus.lsu_had_data_st   = st;
    endtask

    task automatic setwr(input logic [2:0] sel, input logic [63:0] data);
        bus.x_sm_xx_update_dr_en = 1'b1;
        bus.ir_xx_bab_reg_sel    = sel[2];
        bus.ir_xx_bamr_reg_sel   = sel[1];
        bus.ir_xx_bcfg_reg_sel   = sel[0];
        bus.ir_xx_wdata          = data;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [63:0] data);
        setwr(sel, data);
        step("reg_write", 8'h00);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle_inputs();
        bus.ctrl_bkpt_en = 1'b1;
        cpurst_b = 1'b0;
        #12;
        check("reset_outs", {56'h0, outs()}, 64'h0);
        check("reset_bab",  {24'h0, bus.mbkpt_regs_bab}, 64'h0);
        check("reset_bamr", {24'h0, bus.mbkpt_regs_bamr}, 64'h0);
        check("reset_bcfg", {62'h0, bus.mbkpt_regs_bcfg}, 64'h0);
        cpurst_b = 1'b1;
        @(posedge cpuclk);
        #1;

        // exact instruction match, chgflow capture, ack timing
        wr(3'b100, 64'h8000_1000);
        wr(3'b010, 64'h0);
        wr(3'b001, 64'h1);
        check("bab_readback",  {24'h0, bus.mbkpt_regs_bab}, 64'h8000_1000);
        check("bcfg_readback", {62'h0, bus.mbkpt_regs_bcfg}, 64'h1);
        retire(40'h8000_1000, 1'b0, 1'b0); step("inst_hit",          8'b1100_0000);
        retire(40'h8000_1004, 1'b0, 1'b1); step("inst_miss_ack_chg", 8'b1001_0010);
        step("idle_after_ack", 8'b0000_0000);
        retire(40'h8000_1000, 1'b0, 1'b0); step("inst_hit2", 8'b1100_0000);
        bus.rtu_yy_xx_flush = 1'b1;        step("flush_kills_ack", 8'b0000_0000);
        step("idle_after_flush", 8'b0000_0000);

        // masked store hit delivered on next normal retire
        wr(3'b010, 64'hFF);
        wr(3'b100, 64'h2000);
        lsu(40'h20A8, 1'b1);               step("store_hit_pend", 8'b0000_0000);
        retire(40'h3000, 1'b0, 1'b0);      step("data_deliver_st", 8'b1000_1100);
        step("data_ack", 8'b0000_0001);
        retire(40'h3000, 1'b0, 1'b0);      step("pend_cleared", 8'b1000_0000);

        // reverse compare
        wr(3'b010, 64'h0);
        wr(3'b100, 64'h100);
        wr(3'b001, 64'h3);
        retire(40'h100, 1'b0, 1'b0);       step("rc_equal_nohit", 8'b1000_0000);
        retire(40'h104, 1'b0, 1'b0);       step("rc_diff_hit",    8'b1100_0000);
        step("rc_ack", 8'b0000_0010);

        // split group: load hit attaches to last micro-op
        lsu(40'h500, 1'b0);                step("load_hit_pend", 8'b0000_0000);
        retire(40'h100, 1'b1, 1'b0);       step("split1", 8'b1010_0000);
        retire(40'h100, 1'b1, 1'b0);       step("split2", 8'b1010_0000);
        retire(40'h100, 1'b0, 1'b0);       step("split_last_deliver", 8'b1000_1000);
        step("split_data_ack", 8'b0000_0001);

        // flush clears pending, alone and together with a retire
        lsu(40'h500, 1'b0);                step("pend_before_flush", 8'b0000_0000);
        bus.rtu_yy_xx_flush = 1'b1;        step("flush_only", 8'b0000_0000);
        retire(40'h100, 1'b0, 1'b0);       step("no_data_after_flush", 8'b1000_0000);
        lsu(40'h500, 1'b0);                step("pend_before_flush2", 8'b0000_0000);
        retire(40'h100, 1'b0, 1'b0);
        bus.rtu_yy_xx_flush = 1'b1;        step("retire_with_flush", 8'b0000_0000);
        retire(40'h100, 1'b0, 1'b0);       step("no_data_after_flush2", 8'b1000_0000);

        // LSU hit in the same cycle as a consuming retire waits for the next retire
        lsu(40'h500, 1'b0);                step("pend_old", 8'b0000_0000);
        retire(40'h100, 1'b0, 1'b0);
        lsu(40'h500, 1'b1);                step("same_cycle_old_load", 8'b1000_1000);
        retire(40'h100, 1'b0, 1'b0);       step("same_cycle_new_store", 8'b1000_1101);
        step("same_cycle_ack", 8'b0000_0001);
        step("same_cycle_idle", 8'b0000_0000);

        // debug mode suppresses hits
        bus.rtu_yy_xx_dbgon = 1'b1;
        lsu(40'h500, 1'b0);                step("dbgon_load", 8'b0000_0000);
        bus.rtu_yy_xx_dbgon = 1'b1;
        retire(40'h104, 1'b0, 1'b0);       step("dbgon_retire", 8'b1000_0000);
        retire(40'h104, 1'b0, 1'b0);       step("dbgoff_retire", 8'b1100_0000);
        step("dbgoff_ack", 8'b0000_0010);

        // EN=0 disables everything
        wr(3'b001, 64'h2);
        retire(40'h104, 1'b0, 1'b0);       step("en0_inst", 8'b1000_0000);
        lsu(40'h500, 1'b0);                step("en0_load", 8'b0000_0000);
        retire(40'h104, 1'b0, 1'b0);       step("en0_data", 8'b1000_0000);

        // write and retire in the same cycle: old BAB used
        wr(3'b001, 64'h1);
        setwr(3'b100, 64'h200);
        retire(40'h200, 1'b0, 1'b0);       step("wr_same_cycle_old", 8'b1000_0000);
        retire(40'h200, 1'b0, 1'b0);       step("wr_next_cycle_new", 8'b1100_0000);
        step("wr_ack", 8'b0000_0010);
        check("bab_readback2", {24'h0, bus.mbkpt_regs_bab}, 64'h200);

        // BAMR all ones matches anything; upper wdata bits are dropped
        wr(3'b010, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bamr_all_ones", {24'h0, bus.mbkpt_regs_bamr}, 64'hFF_FFFF_FFFF);
        retire(40'h12345, 1'b0, 1'b0);     step("mask_all_hit", 8'b1100_0000);
        step("mask_all_ack", 8'b0000_0010);

        // multiple selects in one cycle
        wr(3'b110, 64'hABC);
        check("multi_bab",  {24'h0, bus.mbkpt_regs_bab}, 64'hABC);
        check("multi_bamr", {24'h0, bus.mbkpt_regs_bamr}, 64'hABC);

        // async reset mid-operation with a pending data hit
        lsu(40'h0ABC, 1'b1);               step("pend_before_reset", 8'b0000_0000);
        #2 cpurst_b = 1'b0;
        #1;
        check("mid_reset_bab",  {24'h0, bus.mbkpt_regs_bab}, 64'h0);
        check("mid_reset_bamr", {24'h0, bus.mbkpt_regs_bamr}, 64'h0);
        check("mid_reset_bcfg", {62'h0, bus.mbkpt_regs_bcfg}, 64'h0);
        check("mid_reset_outs", {56'h0, outs()}, 64'h0);
        #2 cpurst_b = 1'b1;
        retire(40'h0, 1'b0, 1'b0);         step("post_reset_no_data", 8'b1000_0000);
        step("post_reset_idle", 8'b0000_0000);

        check("scoreboard_empty", 64'(sbq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
